// File: rtl/ft_if_pkg.sv
// Shared definitions for the FT245 synchronous FIFO bus blocks:
// FSM encodings, active-low bus levels and a width helper.
package ft_if_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TURN = 2'd1;
    localparam logic [1:0] READ = 2'd2;

    localparam logic HI = 1'b1;
    localparam logic LO = 1'b0;

    // Bits needed to hold values up to value-1; never returns less than 1.
    function automatic int clog2(input int value);
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) >= value) begin
                return i;
            end
        end
        return 31;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered output stage.
// level counts every stored word, including the one on rd_data.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr_next;
    logic [LW-1:0]         level_after_pop;
    logic                  pop;
    logic                  push;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign full            = (level == LW'(DEPTH));
    assign pop             = rd_en & rd_valid;
    assign push            = wr_en & (~full | pop);
    assign rd_ptr_next     = rd_ptr + DEPTH_LOG2'(pop);
    assign level_after_pop = level - LW'(pop);

    // A word written on this edge becomes visible on the following one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            rd_ptr   <= rd_ptr_next;
            level    <= level_after_pop + LW'(push);
            rd_valid <= (level_after_pop != '0);
            if (level_after_pop != '0) begin
                rd_data <= mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/ft245_sync_rx.sv
// FT2232H 245-synchronous receive path: sequences OE#/RD# from RXF#,
// captures host words into a FWFT FIFO and streams them out.
module ft245_sync_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int MAX_BURST  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  rxf_n_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  oe_n_o,
    output logic                  rd_n_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [31:0]           byte_cnt_o,
    output logic                  ovf_o
);

    import ft_if_pkg::*;

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int LW      = DEPTH_LOG2 + 1;
    localparam int LW1     = LW + 1;
    localparam int BURST_W = clog2(MAX_BURST + 1);
    localparam int BW1     = BURST_W + 1;

    localparam logic [LW-1:0]  START_LEVEL = LW'(DEPTH - 3);
    localparam logic [LW1-1:0] STOP_LEVEL  = LW1'(DEPTH - 1);
    localparam logic [BW1-1:0] BURST_LIMIT = BW1'(MAX_BURST);

    logic [1:0]         state;
    logic               oe_n;
    logic               rd_n;
    logic [BURST_W-1:0] burst_cnt;
    logic [BW1-1:0]     burst_next;
    logic [LW1-1:0]     level_next;
    logic [31:0]        byte_cnt;
    logic               ovf;
    logic               fifo_full;
    logic               capture;
    logic               pop;
    logic               wr_ok;
    logic               start_ok;
    logic               burst_done;
    logic               exit_read;

    // The bus hands over a word whenever RD# is low and the host still has data.
    assign capture    = (rd_n == LO) && (rxf_n_i == LO);
    assign pop        = m_valid_o & m_ready_i;
    assign wr_ok      = capture & (~fifo_full | pop);
    assign level_next = {1'b0, level_o} + LW1'(wr_ok) - LW1'(pop);
    assign burst_next = {1'b0, burst_cnt} + BW1'(capture);

    // Starting at DEPTH-3 leaves room for the exit-edge word of the longest burst.
    assign start_ok   = enable_i && (rxf_n_i == LO) && (level_o <= START_LEVEL);
    assign burst_done = (MAX_BURST != 0) && (burst_next >= BURST_LIMIT);
    assign exit_read  = (rxf_n_i == HI) || (level_next >= STOP_LEVEL) || burst_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            oe_n      <= HI;
            rd_n      <= HI;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd_n <= HI;
                    if (start_ok) begin
                        state     <= TURN;
                        oe_n      <= LO;
                        burst_cnt <= '0;
                    end else begin
                        oe_n <= HI;
                    end
                end
                TURN: begin
                    state <= READ;
                    oe_n  <= LO;
                    rd_n  <= LO;
                end
                READ: begin
                    burst_cnt <= burst_next[BURST_W-1:0];
                    if (exit_read) begin
                        state <= IDLE;
                        oe_n  <= HI;
                        rd_n  <= HI;
                    end
                end
                default: begin
                    state <= IDLE;
                    oe_n  <= HI;
                    rd_n  <= HI;
                end
            endcase
        end
    end

    // Dropped words still count as bus traffic; overflow stays set until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (capture) begin
                byte_cnt <= byte_cnt + 32'd1;
            end
            if (capture && fifo_full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .wr_en    (capture),
        .wr_data  (data_i),
        .rd_en    (m_ready_i),
        .rd_data  (m_data_o),
        .rd_valid (m_valid_o),
        .level    (level_o),
        .full     (fifo_full)
    );

    assign oe_n_o     = oe_n;
    assign rd_n_o     = rd_n;
    assign byte_cnt_o = byte_cnt;
    assign ovf_o      = ovf;

endmodule

// File: tb/tb_ft245_sync_rx.sv
// Scoreboard bench for ft245_sync_rx: a host model feeds the FT bus while
// a monitor checks every streamed word against the expected queue.
module tb_ft245_sync_rx;

    localparam int DW  = 8;
    localparam int DL2 = 4;
    localparam int MB  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        rxf_n = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        m_ready = 1'b0;
    logic        oe_n;
    logic        rd_n;
    logic [7:0]  m_data;
    logic        m_valid;
    logic [4:0]  level;
    logic [31:0] byte_cnt;
    logic        ovf;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  exp_q[$];
    int          cap_cycles[$];
    int          burst_exp[10] = '{3, 4, 5, 6, 9, 10, 11, 12, 15, 16};
    int          rst_caps;
    int          rst_cyc;
    bit          rst_cap;

    always #5 clk = ~clk;

    ft245_sync_rx #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL2),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (enable),
        .rxf_n_i    (rxf_n),
        .data_i     (data),
        .oe_n_o     (oe_n),
        .rd_n_o     (rd_n),
        .m_data_o   (m_data),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready),
        .level_o    (level),
        .byte_cnt_o (byte_cnt),
        .ovf_o      (ovf)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host model: presents consecutive words, advancing only after a capture.
    task automatic applyStimulus(input logic [7:0] first, input int count, input int budget);
        int sent;
        int c;
        bit cap;
        sent = 0;
        c = 0;
        cap_cycles.delete();
        for (int i = 0; i < count; i++) begin
            exp_q.push_back(first + 8'(i));
        end
        data = first;
        rxf_n = 1'b0;
        while (sent < count && c < budget) begin
            @(negedge clk);
            cap = (rd_n == 1'b0) && (rxf_n == 1'b0);
            @(posedge clk);
            #1;
            c++;
            if (cap) begin
                cap_cycles.push_back(c);
                sent++;
                data = first + 8'(sent);
            end
        end
        rxf_n = 1'b1;
        checkOutput("host_words_taken", sent, count);
    endtask

    // Monitor: every stream transfer pops the oldest expected word.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL stream_extra: got 0x%0h, expected no word", m_data);
            end else begin
                checkOutput("stream_data", m_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) tick();
        checkOutput("rst_oe_n", oe_n, 1);
        checkOutput("rst_rd_n", rd_n, 1);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_byte_cnt", byte_cnt, 0);
        checkOutput("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        // Single word 0xA5
        enable = 1'b1;
        m_ready = 1'b1;
        applyStimulus(8'hA5, 1, 50);
        checkOutput("single_cap_cycle", cap_cycles[0], 3);
        checkOutput("single_valid_latency0", m_valid, 0);
        tick();
        checkOutput("single_valid_latency1", m_valid, 1);
        checkOutput("single_data_head", m_data, 8'hA5);
        repeat (3) tick();
        checkOutput("single_byte_cnt", byte_cnt, 1);
        checkOutput("single_idle_oe_n", oe_n, 1);
        checkOutput("single_idle_rd_n", rd_n, 1);
        checkOutput("single_level", level, 0);

        // Burst limit of 4 with 10 words queued by the host
        applyStimulus(8'h00, 10, 200);
        checkOutput("burst_cap_count", cap_cycles.size(), 10);
        for (int i = 0; i < 10 && i < cap_cycles.size(); i++) begin
            checkOutput("burst_cap_cycle", cap_cycles[i], burst_exp[i]);
        end
        repeat (5) tick();
        checkOutput("burst_byte_cnt", byte_cnt, 11);
        checkOutput("burst_level", level, 0);

        // Backpressure: reads stop at DEPTH-1 and resume without loss
        m_ready = 1'b0;
        fork
            applyStimulus(8'h10, 20, 600);
            begin
                repeat (60) tick();
                checkOutput("bp_level", level, 15);
                checkOutput("bp_rd_n", rd_n, 1);
                checkOutput("bp_oe_n", oe_n, 1);
                checkOutput("bp_ovf", ovf, 0);
                checkOutput("bp_byte_cnt", byte_cnt, 26);
                m_ready = 1'b1;
            end
        join
        repeat (30) tick();
        checkOutput("bp_drain_level", level, 0);
        checkOutput("bp_drain_ovf", ovf, 0);
        checkOutput("bp_drain_byte_cnt", byte_cnt, 31);

        // Forced overflow: fill to 15, then hold RD# low for two extra captures
        m_ready = 1'b0;
        applyStimulus(8'h40, 15, 200);
        checkOutput("ovf_pre_level", level, 15);
        data = 8'h60;
        rxf_n = 1'b0;
        force dut.rd_n = 1'b0;
        exp_q.push_back(8'h60);
        tick();
        checkOutput("ovf_full_level", level, 16);
        checkOutput("ovf_not_yet", ovf, 0);
        data = 8'h61;
        tick();
        rxf_n = 1'b1;
        release dut.rd_n;
        checkOutput("ovf_set", ovf, 1);
        checkOutput("ovf_level_unchanged", level, 16);
        checkOutput("ovf_byte_cnt", byte_cnt, 48);
        repeat (3) tick();
        checkOutput("ovf_sticky", ovf, 1);
        m_ready = 1'b1;
        repeat (25) tick();
        checkOutput("ovf_drain_level", level, 0);
        checkOutput("ovf_sticky_after_drain", ovf, 1);

        // Reset in the middle of a burst after 3 captures
        m_ready = 1'b0;
        data = 8'h80;
        rxf_n = 1'b0;
        rst_caps = 0;
        rst_cyc = 0;
        while (rst_caps < 3 && rst_cyc < 40) begin
            @(negedge clk);
            rst_cap = (rd_n == 1'b0) && (rxf_n == 1'b0);
            @(posedge clk);
            #1;
            rst_cyc++;
            if (rst_cap) begin
                rst_caps++;
                data = 8'h80 + 8'(rst_caps);
            end
        end
        checkOutput("mid_caps", rst_caps, 3);
        checkOutput("mid_rd_n_low", rd_n, 0);
        checkOutput("mid_level", level, 3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_oe_n", oe_n, 1);
        checkOutput("mid_rst_rd_n", rd_n, 1);
        checkOutput("mid_rst_level", level, 0);
        checkOutput("mid_rst_byte_cnt", byte_cnt, 0);
        checkOutput("mid_rst_m_valid", m_valid, 0);
        checkOutput("mid_rst_ovf", ovf, 0);
        rxf_n = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Byte counter wrap
        force dut.byte_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.byte_cnt;
        tick();
        checkOutput("wrap_preload", byte_cnt, 32'hFFFF_FFFE);
        m_ready = 1'b1;
        applyStimulus(8'hC0, 3, 100);
        repeat (5) tick();
        checkOutput("wrap_byte_cnt", byte_cnt, 1);

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
